mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64: byte address width, all ports.
REQ-002 Parameter DATA_W, default 64: data width, all ports.
REQ-003 Parameter MAX_D_STREAK, default 4: consecutive data grants allowed while a fetch waits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 i_req  input  1  fetch request; held until i_ready observed.
REQ-007 i_addr  input  ADDR_W  fetch address (read-only port).
REQ-008 i_ready  output  1  one-cycle pulse, fetch complete.
REQ-009 i_rdata  output  DATA_W  fetch data, valid while i_ready=1.
REQ-010 d_req  input  1  data request; held until d_ready observed.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  ADDR_W  data address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_ready  output  1  one-cycle pulse, data access complete.
REQ-015 d_rdata  output  DATA_W  load data, valid while d_ready=1; 0 after a store.
REQ-016 mem_req  output  1  request to the shared single-port memory.
REQ-017 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  latched command to memory.
REQ-018 mem_ack  input  1  memory completion pulse; mem_rdata valid the same cycle.
REQ-019 mem_rdata  input  DATA_W  memory read data.

Function
REQ-020 FSM states: IDLE, I_BUSY, D_BUSY, I_RESP, D_RESP.
REQ-021 IDLE: sample requests at the edge; grant the winner, latch addr/we/wdata, go to x_BUSY; no requests -> stay IDLE.
REQ-022 Arbitration: d_req wins over i_req, except i_req wins when streak counter == MAX_D_STREAK.
REQ-023 Streak counter: +1 per data grant while i_req=1 at grant; cleared on any fetch grant or any data grant with i_req=0; saturates at MAX_D_STREAK.
REQ-024 x_BUSY: mem_req=1 and command outputs stable from latches; input address/data changes ignored.
REQ-025 x_BUSY with mem_ack=1 at edge: register mem_rdata (0 for stores), go to x_RESP; without ack stay, no timeout.
REQ-026 x_RESP: matching x_ready=1 for exactly one cycle, mem_req=0, then IDLE unconditionally.
REQ-027 Minimum access = 4 cycles (IDLE, BUSY, RESP, IDLE); with ack on the first BUSY cycle, ready appears 2 edges after grant.
REQ-028 Requester seeing x_ready at an edge either drops req or presents the next request by the following IDLE sample; no back-to-back grant without an IDLE cycle.
REQ-029 i_rdata/d_rdata hold the last returned value between pulses.
REQ-030 mem_ack outside x_BUSY is ignored.
REQ-031 Never both ready outputs in one cycle; mem_req never high outside x_BUSY.

Reset
REQ-032 rst=0 forces asynchronously: state IDLE, streak 0, mem_req 0, i_ready/d_ready 0, all data/address registers 0.
REQ-033 Reset mid-access abandons the transfer; the memory model drops any request whose mem_req falls before ack.
REQ-034 First grant possible at the first rising edge after rst returns to 1.

Structure
REQ-035 FSM state enum and default widths live in the shared CPU package, imported by the arbiter and the pipelined CPU.
REQ-036 One sub-module, arb_streak_counter (saturating counter with clear), is natural; everything else stays in mem_arbiter.

Verification
REQ-037 Single fetch: i_req=1, i_addr=0x40, ack after 1 BUSY cycle with rdata 0x91000421 -> i_ready pulse at 2nd edge after grant, i_rdata=0x91000421.
REQ-038 Collision: i_req and d_req (load 0x100) together, i_addr=0x0 -> data granted first, fetch granted in the following IDLE; d_ready precedes i_ready.
REQ-039 Starvation: d_req held continuously with i_req=1, MAX_D_STREAK=4 -> exactly 4 data grants, then fetch grant, then streak 0.
REQ-040 Store: d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF during D_BUSY; d_ready with d_rdata=0.
REQ-041 Long latency plus address change: ack after 7 cycles, d_addr changed mid-BUSY -> mem_addr holds original value for all 7 cycles.
REQ-042 Reset mid-access: rst=0 during D_BUSY -> mem_req and ready fall without waiting for an edge; a following ack is ignored; next request serviced normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: arbiter FSM state encoding, default bus widths and a
// width helper for saturating counters.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF       = 64;
    localparam int unsigned DATA_W_DEF       = 64;
    localparam int unsigned MAX_D_STREAK_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_BUSY = 3'd1,
        ST_D_BUSY = 3'd2,
        ST_I_RESP = 3'd3,
        ST_D_RESP = 3'd4
    } arb_state_t;

    // Bits needed to hold 0..max_val. Never returns 0, so MAX_D_STREAK=0 still
    // yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async active-low), inc (count up, holds at MAX_VAL),
//        clr (return to 0, wins over inc), count (current value).
module arb_streak_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_VAL = MAX_D_STREAK_DEF,
    parameter int unsigned CNT_W   = cnt_width(MAX_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(MAX_VAL))) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// memory. Data wins by default; a waiting fetch is forced through after
// MAX_D_STREAK consecutive data grants.
// Ports: clk, rst (async active-low);
//        fetch  i_req/i_addr -> i_ready/i_rdata;
//        data   d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata;
//        memory mem_req/mem_we/mem_addr/mem_wdata <- mem_ack/mem_rdata.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = cnt_width(MAX_D_STREAK);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              grant_i;
    logic              grant_d;
    logic [CNT_W-1:0]  streak;
    logic              streak_full;

    logic              mem_req_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              i_ready_nxt;
    logic              d_ready_nxt;
    logic [DATA_W-1:0] i_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_nxt;

    assign streak_full = (streak == CNT_W'(MAX_D_STREAK));

    // Streak of data grants taken while a fetch was waiting.
    arb_streak_counter #(
        .MAX_VAL (MAX_D_STREAK),
        .CNT_W   (CNT_W)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc   (grant_d && i_req),
        .clr   (grant_i || (grant_d && !i_req)),
        .count (streak)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant decision.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (d_req && !(i_req && streak_full)) begin
                    grant_d   = 1'b1;
                    state_nxt = ST_D_BUSY;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = ST_I_BUSY;
                end
            end
            ST_I_BUSY: if (mem_ack) state_nxt = ST_I_RESP;
            ST_D_BUSY: if (mem_ack) state_nxt = ST_D_RESP;
            ST_I_RESP: state_nxt = ST_IDLE;
            ST_D_RESP: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so every output is a flop.
    always_comb begin
        mem_req_nxt   = (state_nxt == ST_I_BUSY) || (state_nxt == ST_D_BUSY);
        i_ready_nxt   = (state_nxt == ST_I_RESP);
        d_ready_nxt   = (state_nxt == ST_D_RESP);
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        if (grant_d) begin
            mem_we_nxt    = d_we;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
        end else if (grant_i) begin
            mem_we_nxt    = 1'b0;
            mem_addr_nxt  = i_addr;
            mem_wdata_nxt = '0;
        end
        if ((state == ST_I_BUSY) && mem_ack) begin
            i_rdata_nxt = mem_rdata;
        end
        if ((state == ST_D_BUSY) && mem_ack) begin
            d_rdata_nxt = mem_we ? '0 : mem_rdata;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            i_ready   <= i_ready_nxt;
            d_ready   <= d_ready_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default parameters).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_ready;
    logic [63:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ready;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();

        // Reset state
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_i_ready", 64'(i_ready), 64'd0);
        check("rst_d_ready", 64'(d_ready), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_i_rdata", i_rdata, 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        rst = 1'b1;

        // Single fetch, ack on first BUSY cycle
        i_req = 1'b1; i_addr = 64'h40;
        tick();
        check("f_mem_req", 64'(mem_req), 64'd1);
        check("f_mem_addr", mem_addr, 64'h40);
        check("f_mem_we", 64'(mem_we), 64'd0);
        check("f_no_ready", 64'(i_ready), 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'h91000421;
        tick();
        mem_ack = 1'b0;
        check("f_i_ready", 64'(i_ready), 64'd1);
        check("f_i_rdata", i_rdata, 64'h91000421);
        check("f_resp_mem_req", 64'(mem_req), 64'd0);
        check("f_resp_d_ready", 64'(d_ready), 64'd0);
        i_req = 1'b0;
        tick();
        check("f_ready_drop", 64'(i_ready), 64'd0);
        check("f_rdata_hold", i_rdata, 64'h91000421);
        tick();
        check("f_idle_mem_req", 64'(mem_req), 64'd0);

        // Collision: data first, then fetch
        i_req = 1'b1; i_addr = 64'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        tick();
        check("c_d_grant_addr", mem_addr, 64'h100);
        check("c_d_grant_req", 64'(mem_req), 64'd1);
        mem_ack = 1'b1; mem_rdata = 64'h1234;
        tick();
        mem_ack = 1'b0;
        check("c_d_ready", 64'(d_ready), 64'd1);
        check("c_d_rdata", d_rdata, 64'h1234);
        check("c_i_not_ready", 64'(i_ready), 64'd0);
        d_req = 1'b0;
        tick();
        check("c_idle_mem_req", 64'(mem_req), 64'd0);
        tick();
        check("c_i_grant_req", 64'(mem_req), 64'd1);
        check("c_i_grant_addr", mem_addr, 64'h0);
        mem_ack = 1'b1; mem_rdata = 64'h5555;
        tick();
        mem_ack = 1'b0;
        check("c_i_ready", 64'(i_ready), 64'd1);
        check("c_i_rdata", i_rdata, 64'h5555);
        check("c_d_not_ready", 64'(d_ready), 64'd0);
        i_req = 1'b0;
        tick(); tick();

        // Ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 64'hBAD;
        tick();
        mem_ack = 1'b0;
        check("ia_mem_req", 64'(mem_req), 64'd0);
        check("ia_d_ready", 64'(d_ready), 64'd0);
        check("ia_i_ready", 64'(i_ready), 64'd0);
        check("ia_d_rdata", d_rdata, 64'h1234);
        check("ia_i_rdata", i_rdata, 64'h5555);

        // Starvation: four data grants, then the fetch
        i_req = 1'b1; i_addr = 64'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("s_d_grant_addr", mem_addr, 64'h300);
            mem_ack = 1'b1; mem_rdata = 64'(k + 16);
            tick();
            mem_ack = 1'b0;
            check("s_d_ready", 64'(d_ready), 64'd1);
            check("s_d_rdata", d_rdata, 64'(k + 16));
            tick();
        end
        tick();
        check("s_i_grant_addr", mem_addr, 64'h200);
        check("s_i_grant_we", 64'(mem_we), 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'hF00D;
        tick();
        mem_ack = 1'b0;
        check("s_i_ready", 64'(i_ready), 64'd1);
        check("s_i_rdata", i_rdata, 64'hF00D);
        tick();
        tick();
        // Streak cleared: data wins again with both requests present
        check("s_after_addr", mem_addr, 64'h300);
        mem_ack = 1'b1; mem_rdata = 64'h77;
        tick();
        mem_ack = 1'b0;
        check("s_after_d_ready", 64'(d_ready), 64'd1);
        d_req = 1'b0; i_req = 1'b0;
        tick(); tick();

        // Store
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h8; d_wdata = 64'hDEADBEEF;
        tick();
        check("w_mem_req", 64'(mem_req), 64'd1);
        check("w_mem_we", 64'(mem_we), 64'd1);
        check("w_mem_wdata", mem_wdata, 64'hDEADBEEF);
        check("w_mem_addr", mem_addr, 64'h8);
        mem_ack = 1'b1; mem_rdata = 64'hFFFF;
        tick();
        mem_ack = 1'b0;
        check("w_d_ready", 64'(d_ready), 64'd1);
        check("w_d_rdata", d_rdata, 64'd0);
        d_req = 1'b0; d_we = 1'b0;
        tick(); tick();

        // Long latency with address change during BUSY
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500;
        tick();
        d_addr = 64'h999; d_wdata = 64'h1;
        for (int c = 0; c < 7; c++) begin
            check("l_mem_addr", mem_addr, 64'h500);
            check("l_mem_req", 64'(mem_req), 64'd1);
            check("l_no_ready", 64'(d_ready), 64'd0);
            if (c == 6) begin
                mem_ack = 1'b1; mem_rdata = 64'h7777;
            end
            tick();
        end
        mem_ack = 1'b0;
        check("l_d_ready", 64'(d_ready), 64'd1);
        check("l_d_rdata", d_rdata, 64'h7777);
        d_req = 1'b0;
        tick(); tick();

        // Reset in the middle of a data access
        d_req = 1'b1; d_addr = 64'h600;
        tick();
        check("r_mem_req", 64'(mem_req), 64'd1);
        tick();
        #2 rst = 1'b0;
        #1;
        check("r_async_mem_req", 64'(mem_req), 64'd0);
        check("r_async_d_ready", 64'(d_ready), 64'd0);
        check("r_async_mem_addr", mem_addr, 64'd0);
        d_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 64'hEEEE;
        tick();
        rst = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("r_ack_ign_ready", 64'(d_ready), 64'd0);
        check("r_ack_ign_rdata", d_rdata, 64'd0);
        check("r_ack_ign_req", 64'(mem_req), 64'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h700;
        tick();
        check("r_next_req", 64'(mem_req), 64'd1);
        check("r_next_addr", mem_addr, 64'h700);
        mem_ack = 1'b1; mem_rdata = 64'hABC;
        tick();
        mem_ack = 1'b0;
        check("r_next_ready", 64'(d_ready), 64'd1);
        check("r_next_rdata", d_rdata, 64'hABC);
        d_req = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
